// File: rtl/attn_pkg.sv
// Shared widths, config bundle and I-BERT polynomial constants for the softmax path.
package attn_pkg;

  localparam int Q_WIDTH_DEF    = 16;
  localparam int OUT_WIDTH_DEF  = 32;
  localparam int LANES_DEF      = 4;
  localparam int RECIP_BITS_DEF = 16;

  typedef struct packed {
    logic [Q_WIDTH_DEF-1:0]    q_ln2;
    logic [RECIP_BITS_DEF:0]   inv;
    logic [Q_WIDTH_DEF-1:0]    qb;
    logic [OUT_WIDTH_DEF-1:0]  qc;
  } exp_cfg_t;

  // L(p) = a*(p + b)^2 + c, used host-side to derive qb/qc from the row scale
  localparam real IBERT_A = 0.3585;
  localparam real IBERT_B = 1.353;
  localparam real IBERT_C = 0.344;

endpackage

// File: rtl/i_exp_lane.sv
// One lane of the integer exp pipeline: clamp/reciprocal multiply, quotient
// correction, polynomial with saturation, final power-of-two shift.
module i_exp_lane
  import attn_pkg::*;
#(
  parameter int Q_WIDTH    = Q_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int RECIP_BITS = RECIP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [Q_WIDTH-1:0]   in_q,
  input  logic [Q_WIDTH-1:0]   cfg_q_ln2,
  input  logic [RECIP_BITS:0]  cfg_inv,
  input  logic [Q_WIDTH-1:0]   cfg_qb,
  input  logic [OUT_WIDTH-1:0] cfg_qc,
  output logic [OUT_WIDTH-1:0] out_q,
  output logic                 out_clamp
);

  localparam int PW  = Q_WIDTH + RECIP_BITS + 1;
  localparam int ZW  = Q_WIDTH + 1;
  localparam int MW  = ZW + Q_WIDTH;
  localparam int TW  = Q_WIDTH + 1;
  localparam int SQW = 2 * TW;
  localparam int SW  = ((SQW > OUT_WIDTH) ? SQW : OUT_WIDTH) + 1;

  logic [Q_WIDTH-1:0]   n_s, n_r, r_s, r_r;
  logic [PW-1:0]        p_s, p_r;
  logic [ZW-1:0]        z0_s, z_s, z2_r, z3_r;
  logic [MW-1:0]        r0_s;
  logic [TW-1:0]        t_s, mag_s;
  logic [SW-1:0]        sum_s;
  logic [OUT_WIDTH-1:0] ql_s, ql_r, res_s;
  logic                 clamp_s, clamp1_r, clamp2_r, clamp3_r;

  // Per-stage combinational datapath feeding the stage registers
  always_comb begin
    n_s     = '0;
    clamp_s = 1'b0;
    if (in_q[Q_WIDTH-1]) begin
      n_s = ~in_q + Q_WIDTH'(1);
    end else if (in_q != '0) begin
      clamp_s = 1'b1;
    end else begin
      clamp_s = 1'b0;
    end
    p_s = PW'(n_s) * PW'(cfg_inv);

    // floor(2^R/q_ln2) never overshoots, so r0 >= 0 and needs at most one step up
    z0_s = ZW'(p_r >> RECIP_BITS);
    r0_s = MW'(n_r) - MW'(z0_s) * MW'(cfg_q_ln2);
    if (r0_s >= MW'(cfg_q_ln2)) begin
      z_s = z0_s + ZW'(1);
      r_s = Q_WIDTH'(r0_s - MW'(cfg_q_ln2));
    end else begin
      z_s = z0_s;
      r_s = Q_WIDTH'(r0_s);
    end

    t_s   = {cfg_qb[Q_WIDTH-1], cfg_qb} - {1'b0, r_r};
    mag_s = t_s[TW-1] ? (~t_s + TW'(1)) : t_s;
    sum_s = SW'(SQW'(mag_s) * SQW'(mag_s)) + SW'(cfg_qc);
    if (sum_s > SW'({OUT_WIDTH{1'b1}})) begin
      ql_s = '1;
    end else begin
      ql_s = OUT_WIDTH'(sum_s);
    end

    if (32'(z3_r) >= 32'(OUT_WIDTH)) begin
      res_s = '0;
    end else begin
      res_s = ql_r >> z3_r;
    end
  end

  // Stage registers, all advancing together on the shared enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r       <= '0;
      p_r       <= '0;
      clamp1_r  <= 1'b0;
      z2_r      <= '0;
      r_r       <= '0;
      clamp2_r  <= 1'b0;
      z3_r      <= '0;
      ql_r      <= '0;
      clamp3_r  <= 1'b0;
      out_q     <= '0;
      out_clamp <= 1'b0;
    end else if (en) begin
      n_r       <= n_s;
      p_r       <= p_s;
      clamp1_r  <= clamp_s;
      z2_r      <= z_s;
      r_r       <= r_s;
      clamp2_r  <= clamp1_r;
      z3_r      <= z2_r;
      ql_r      <= ql_s;
      clamp3_r  <= clamp2_r;
      out_q     <= res_s;
      out_clamp <= clamp3_r;
    end
  end

endmodule

// File: rtl/i_exp_vec.sv
// Multi-lane integer exp unit: shared valid pipeline, valid/ready handshake
// and per-row config registers around LANES copies of i_exp_lane.
module i_exp_vec
  import attn_pkg::*;
#(
  parameter int Q_WIDTH    = Q_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int RECIP_BITS = RECIP_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  logic [Q_WIDTH-1:0]         cfg_q_ln2,
  input  logic [RECIP_BITS:0]        cfg_inv_q_ln2,
  input  logic [Q_WIDTH-1:0]         cfg_qb,
  input  logic [OUT_WIDTH-1:0]       cfg_qc,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*Q_WIDTH-1:0]   in_q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*OUT_WIDTH-1:0] out_q,
  output logic [LANES-1:0]           out_clamp
);

  logic                 en_s;
  logic [2:0]           vld_r;
  logic [Q_WIDTH-1:0]   q_ln2_r, qb_r;
  logic [RECIP_BITS:0]  inv_r;
  logic [OUT_WIDTH-1:0] qc_r;

  // Whole pipeline stalls only when a finished beat is waiting on the consumer
  always_comb begin
    en_s     = !out_valid || out_ready;
    in_ready = en_s;
    busy     = (|vld_r) || out_valid;
  end

  // Valid shift register and output valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r     <= 3'b000;
      out_valid <= 1'b0;
    end else if (en_s) begin
      vld_r     <= {vld_r[1:0], in_valid};
      out_valid <= vld_r[2];
    end
  end

  // Config is frozen while anything is in flight so a beat never sees mixed constants
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ln2_r <= '0;
      inv_r   <= '0;
      qb_r    <= '0;
      qc_r    <= '0;
    end else if (cfg_load && !busy) begin
      q_ln2_r <= cfg_q_ln2;
      inv_r   <= cfg_inv_q_ln2;
      qb_r    <= cfg_qb;
      qc_r    <= cfg_qc;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    i_exp_lane #(
      .Q_WIDTH    (Q_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .RECIP_BITS (RECIP_BITS)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (en_s),
      .in_q      (in_q[i*Q_WIDTH +: Q_WIDTH]),
      .cfg_q_ln2 (q_ln2_r),
      .cfg_inv   (inv_r),
      .cfg_qb    (qb_r),
      .cfg_qc    (qc_r),
      .out_q     (out_q[i*OUT_WIDTH +: OUT_WIDTH]),
      .out_clamp (out_clamp[i])
    );
  end

endmodule

// File: tb/tb_i_exp_vec.sv
// Scoreboard bench for i_exp_vec: expected beats queued at acceptance, compared at output.
module tb_i_exp_vec;
  import attn_pkg::*;

  localparam int QW = 16;
  localparam int OW = 32;
  localparam int LN = 4;
  localparam int RB = 16;
  localparam int VW = LN * OW;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_load;
  logic [QW-1:0]   cfg_q_ln2;
  logic [RB:0]     cfg_inv_q_ln2;
  logic [QW-1:0]   cfg_qb;
  logic [OW-1:0]   cfg_qc;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [LN*QW-1:0] in_q;
  logic            out_valid;
  logic            out_ready;
  logic [VW-1:0]   out_q;
  logic [LN-1:0]   out_clamp;

  i_exp_vec #(.Q_WIDTH(QW), .OUT_WIDTH(OW), .LANES(LN), .RECIP_BITS(RB)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_q_ln2(cfg_q_ln2),
    .cfg_inv_q_ln2(cfg_inv_q_ln2), .cfg_qb(cfg_qb), .cfg_qc(cfg_qc), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_clamp(out_clamp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] q;
    logic [LN-1:0] c;
  } beat_t;

  beat_t    sb_q[$];
  int       n_vec = 0;
  int       n_miss = 0;
  exp_cfg_t cfg_m;

  task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference uses true division instead of the reciprocal datapath
  function automatic logic [OW:0] model(input logic signed [QW-1:0] q, input exp_cfg_t c);
    longint n, z, r, t, ql, res;
    longint max_v = 64'h0000_0000_FFFF_FFFF;
    n   = (q > 0) ? 64'sd0 : -longint'(q);
    z   = n / longint'(c.q_ln2);
    r   = n % longint'(c.q_ln2);
    t   = longint'($signed(c.qb)) - r;
    ql  = t * t + longint'(c.qc);
    if (ql > max_v) ql = max_v;
    res = (z >= OW) ? 64'sd0 : (ql >> z);
    return {(q > 0), OW'(res)};
  endfunction

  function automatic beat_t expect_beat(input logic [LN*QW-1:0] q);
    beat_t       e;
    logic [OW:0] m;
    for (int i = 0; i < LN; i++) begin
      m = model($signed(q[i*QW +: QW]), cfg_m);
      e.q[i*OW +: OW] = m[OW-1:0];
      e.c[i] = m[OW];
    end
    return e;
  endfunction

  function automatic logic [LN*QW-1:0] pack_q(input int a0, input int a1, input int a2, input int a3);
    return {QW'(a3), QW'(a2), QW'(a1), QW'(a0)};
  endfunction

  function automatic logic [VW-1:0] pack_o(input longint a0, input longint a1, input longint a2, input longint a3);
    return {OW'(a3), OW'(a2), OW'(a1), OW'(a0)};
  endfunction

  task automatic apply_cfg(input exp_cfg_t c);
    cfg_q_ln2     = c.q_ln2;
    cfg_inv_q_ln2 = c.inv;
    cfg_qb        = c.qb;
    cfg_qc        = c.qc;
    cfg_load      = 1'b1;
    @(posedge clk); #1;
    cfg_load      = 1'b0;
  endtask

  task automatic send(input logic [LN*QW-1:0] q, input beat_t e);
    logic acc = 1'b0;
    int   g = 0;
    in_valid = 1'b1;
    in_q     = q;
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      g++;
    end
    if (acc) sb_q.push_back(e);
    else check_eq("send_timeout", VW'(1), VW'(0));
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((busy || sb_q.size() != 0) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("drain_busy", VW'(busy), VW'(0));
    check_eq("drain_sb", VW'(sb_q.size()), VW'(0));
  endtask

  // Output monitor: held beats are re-checked every stalled cycle against the same entry
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_out", VW'(1), VW'(0));
      end else begin
        check_eq("out_q", out_q, sb_q[0].q);
        check_eq("out_clamp", VW'(out_clamp), VW'(sb_q[0].c));
        if (out_ready) void'(sb_q.pop_front());
      end
      if (!out_ready) check_eq("in_ready_stall", VW'(in_ready), VW'(0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    exp_cfg_t   cfg0, cfg_new, cfg_sat;
    logic [LN*QW-1:0] qv;
    int         lat;
    int         seen;

    $display("I-BERT poly a=%f b=%f c=%f", IBERT_A, IBERT_B, IBERT_C);
    cfg0    = '{q_ln2: 16'd177, inv: 17'd370, qb: 16'd346, qc: 32'd62885};
    cfg_new = '{q_ln2: 16'd100, inv: 17'd655, qb: 16'd346, qc: 32'd62885};
    cfg_sat = '{q_ln2: 16'd177, inv: 17'd370, qb: 16'd346, qc: 32'hFFFF_FF00};

    rst = 1'b1; cfg_load = 1'b0; cfg_q_ln2 = '0; cfg_inv_q_ln2 = '0; cfg_qb = '0; cfg_qc = '0;
    in_valid = 1'b0; in_q = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_eq("rst_out_valid", VW'(out_valid), VW'(0));
    check_eq("rst_busy", VW'(busy), VW'(0));
    check_eq("rst_out_q", out_q, VW'(0));
    check_eq("rst_in_ready", VW'(in_ready), VW'(1));
    rst = 1'b0;
    @(posedge clk); #1;
    apply_cfg(cfg0);
    cfg_m = cfg0;

    // Basic lanes and latency
    send(pack_q(0, -100, -177, -354),
         '{q: pack_o(182601, 123401, 91300, 45650), c: 4'b0000});
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", VW'(lat), VW'(4));
    wait_drain();

    // Clamp, huge shift, reciprocal correction, small negative
    send(pack_q(5, -32768, -531, -1),
         '{q: pack_o(182601, 0, 22825, 181910), c: 4'b0001});
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back random beats with a 3-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          qv = {$urandom(), $urandom()};
          send(qv, expect_beat(qv));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Config load while busy is ignored
    qv = pack_q(-100, -100, -100, -100);
    send(qv, expect_beat(qv));
    in_valid = 1'b0;
    apply_cfg(cfg_new);
    wait_drain();
    send(qv, expect_beat(qv));
    in_valid = 1'b0;
    wait_drain();
    apply_cfg(cfg_new);
    cfg_m = cfg_new;
    send(qv, '{q: pack_o(91300, 91300, 91300, 91300), c: 4'b0000});
    in_valid = 1'b0;
    wait_drain();

    // Polynomial saturation
    apply_cfg(cfg_sat);
    cfg_m = cfg_sat;
    send(pack_q(0, -177, -32768, 5),
         '{q: pack_o(64'hFFFF_FFFF, 64'h7FFF_FFFF, 0, 64'hFFFF_FFFF), c: 4'b1000});
    in_valid = 1'b0;
    wait_drain();
    apply_cfg(cfg0);
    cfg_m = cfg0;

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      qv = pack_q(-i, -50 * i, -177 * i, -7 * i);
      send(qv, expect_beat(qv));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_valid", VW'(out_valid), VW'(1));
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", VW'(out_valid), VW'(0));
    check_eq("mid_rst_busy", VW'(busy), VW'(0));
    check_eq("mid_rst_out_q", out_q, VW'(0));
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("post_rst_ready", VW'(in_ready), VW'(1));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("post_rst_stale", VW'(seen), VW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
